// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one physical memory port between an instruction-fetch port
// (A, read-only) and a data port (B, read/write). The winning request is
// latched on grant and replayed unchanged on pmem_* until pmem_resp.
// The completion pulse is routed only to the granted requester.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   mem_*_a                 port A request (read-only) / response
//   mem_*_b                 port B request (read/write) / response
//   pmem_*                  downstream memory port
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  when both ports request in IDLE, grant the port that
//                       did not win last time. Undefined: fixed B > A.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_a,
  input  logic [ADDR_WIDTH-1:0] mem_address_a,
  output logic                  mem_resp_a,
  output logic [DATA_WIDTH-1:0] mem_rdata_a,
  input  logic                  mem_read_b,
  input  logic                  mem_write_b,
  input  logic [MASK_WIDTH-1:0] mem_wmask_b,
  input  logic [ADDR_WIDTH-1:0] mem_address_b,
  input  logic [DATA_WIDTH-1:0] mem_wdata_b,
  output logic                  mem_resp_b,
  output logic [DATA_WIDTH-1:0] mem_rdata_b,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [MASK_WIDTH-1:0] pmem_wmask,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_e;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  last_grant_q, last_grant_d;

  logic                  req_a_s;
  logic                  req_b_s;
  logic                  grant_b_s;

  assign req_a_s = mem_read_a;
  assign req_b_s = mem_read_b | mem_write_b;

  // Downstream port is driven purely from the latched request registers.
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_wmask   = wmask_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Read data is broadcast; it is only meaningful alongside the matching resp.
  assign mem_rdata_a = pmem_rdata;
  assign mem_rdata_b = pmem_rdata;

  // State and latched-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wmask_q      <= {MASK_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      last_grant_q <= GRANT_A;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant selection: B wins a tie unless round-robin picks the other port.
  always_comb begin
    grant_b_s = req_b_s;
`ifdef ARB_ROUND_ROBIN_EN
    if (req_a_s && req_b_s) begin
      grant_b_s = (last_grant_q == GRANT_A);
    end else begin
      grant_b_s = req_b_s;
    end
`endif
  end

  // Next-state and request-latch logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_b_s) begin
          state_d      = SERVE_B;
          addr_d       = mem_address_b;
          wmask_d      = mem_wmask_b;
          wdata_d      = mem_wdata_b;
          // A simultaneous read+write from B is treated as a write.
          wr_d         = mem_write_b;
          rd_d         = ~mem_write_b;
          last_grant_d = GRANT_B;
        end else if (req_a_s) begin
          state_d      = SERVE_A;
          addr_d       = mem_address_a;
          wmask_d      = {MASK_WIDTH{1'b1}};
          wdata_d      = {DATA_WIDTH{1'b0}};
          rd_d         = 1'b1;
          wr_d         = 1'b0;
          last_grant_d = GRANT_A;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_A, SERVE_B: begin
        // Completion clears the strobes so the dead IDLE cycle is quiet.
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Response routing: only the granted port, and only if it still requests.
  always_comb begin
    mem_resp_a = 1'b0;
    mem_resp_b = 1'b0;
    if (pmem_resp && (state_q == SERVE_A)) begin
      mem_resp_a = req_a_s;
    end else if (pmem_resp && (state_q == SERVE_B)) begin
      mem_resp_b = req_b_s;
    end else begin
      mem_resp_a = 1'b0;
      mem_resp_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (default parameters).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_a;
  logic [15:0] mem_address_a;
  logic        mem_resp_a;
  logic [15:0] mem_rdata_a;
  logic        mem_read_b;
  logic        mem_write_b;
  logic [1:0]  mem_wmask_b;
  logic [15:0] mem_address_b;
  logic [15:0] mem_wdata_b;
  logic        mem_resp_b;
  logic [15:0] mem_rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_a    (mem_read_a),
    .mem_address_a (mem_address_a),
    .mem_resp_a    (mem_resp_a),
    .mem_rdata_a   (mem_rdata_a),
    .mem_read_b    (mem_read_b),
    .mem_write_b   (mem_write_b),
    .mem_wmask_b   (mem_wmask_b),
    .mem_address_b (mem_address_b),
    .mem_wdata_b   (mem_wdata_b),
    .mem_resp_b    (mem_resp_b),
    .mem_rdata_b   (mem_rdata_b),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wmask    (pmem_wmask),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    mem_read_a    = 1'b0;
    mem_address_a = 16'h0000;
    mem_read_b    = 1'b0;
    mem_write_b   = 1'b0;
    mem_wmask_b   = 2'b00;
    mem_address_b = 16'h0000;
    mem_wdata_b   = 16'h0000;
    pmem_resp     = 1'b0;
    pmem_rdata    = 16'h0000;

    // Reset state
    step();
    check_eq("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    check_eq("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    check_eq("rst_pmem_addr", {16'd0, pmem_address}, 32'd0);
    check_eq("rst_pmem_wmask", {30'd0, pmem_wmask}, 32'd0);
    reset = 1'b0;
    step();

    // Port A read 0x1234, response three cycles into service
    mem_read_a    = 1'b1;
    mem_address_a = 16'h1234;
    settle();
    check_eq("a_idle_no_strobe", {31'd0, pmem_read}, 32'd0);
    step();
    check_eq("a_c1_read", {31'd0, pmem_read}, 32'd1);
    check_eq("a_c1_addr", {16'd0, pmem_address}, 32'h1234);
    check_eq("a_c1_write", {31'd0, pmem_write}, 32'd0);
    check_eq("a_c1_wmask", {30'd0, pmem_wmask}, 32'd3);
    mem_address_a = 16'h5555;
    step();
    check_eq("a_c2_addr_held", {16'd0, pmem_address}, 32'h1234);
    check_eq("a_c2_no_resp", {31'd0, mem_resp_a}, 32'd0);
    step();
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hBEEF;
    settle();
    check_eq("a_resp", {31'd0, mem_resp_a}, 32'd1);
    check_eq("a_rdata", {16'd0, mem_rdata_a}, 32'hBEEF);
    check_eq("a_resp_b_quiet", {31'd0, mem_resp_b}, 32'd0);
    step();
    mem_read_a = 1'b0;
    check_eq("a_after_read", {31'd0, pmem_read}, 32'd0);
    // pmem_resp still high in IDLE: ignored
    check_eq("idle_resp_ign_a", {31'd0, mem_resp_a}, 32'd0);
    check_eq("idle_resp_ign_b", {31'd0, mem_resp_b}, 32'd0);
    pmem_resp = 1'b0;
    step();

    // Simultaneous A read and B write; last grant is A, so B goes first in both modes
    mem_read_a    = 1'b1;
    mem_address_a = 16'h2222;
    mem_write_b   = 1'b1;
    mem_address_b = 16'h0040;
    mem_wdata_b   = 16'h00FF;
    mem_wmask_b   = 2'b01;
    step();
    check_eq("ab_b_write", {31'd0, pmem_write}, 32'd1);
    check_eq("ab_b_read", {31'd0, pmem_read}, 32'd0);
    check_eq("ab_b_addr", {16'd0, pmem_address}, 32'h0040);
    check_eq("ab_b_wdata", {16'd0, pmem_wdata}, 32'h00FF);
    check_eq("ab_b_wmask", {30'd0, pmem_wmask}, 32'd1);
    mem_address_b = 16'h9999;
    mem_wdata_b   = 16'h1111;
    step();
    check_eq("b_addr_stable", {16'd0, pmem_address}, 32'h0040);
    check_eq("b_wdata_stable", {16'd0, pmem_wdata}, 32'h00FF);
    pmem_resp = 1'b1;
    settle();
    check_eq("ab_b_resp", {31'd0, mem_resp_b}, 32'd1);
    check_eq("ab_a_no_resp", {31'd0, mem_resp_a}, 32'd0);
    step();
    pmem_resp   = 1'b0;
    mem_write_b = 1'b0;
    check_eq("ab_dead_read", {31'd0, pmem_read}, 32'd0);
    check_eq("ab_dead_write", {31'd0, pmem_write}, 32'd0);
    step();
    check_eq("ab_a_read", {31'd0, pmem_read}, 32'd1);
    check_eq("ab_a_addr", {16'd0, pmem_address}, 32'h2222);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hCAFE;
    settle();
    check_eq("ab_a_resp", {31'd0, mem_resp_a}, 32'd1);
    check_eq("ab_a_rdata", {16'd0, mem_rdata_a}, 32'hCAFE);
    step();
    pmem_resp  = 1'b0;
    mem_read_a = 1'b0;
    step();

    // A drops its request before completion: response discarded
    mem_read_a    = 1'b1;
    mem_address_a = 16'h0300;
    step();
    check_eq("drop_read", {31'd0, pmem_read}, 32'd1);
    mem_read_a = 1'b0;
    step();
    pmem_resp = 1'b1;
    settle();
    check_eq("drop_no_resp", {31'd0, mem_resp_a}, 32'd0);
    step();
    pmem_resp = 1'b0;
    check_eq("drop_strobe_off", {31'd0, pmem_read}, 32'd0);
    // Back in IDLE: a fresh B read is granted on the next edge
    mem_read_b    = 1'b1;
    mem_address_b = 16'h0500;
    step();
    check_eq("drop_idle_b_read", {31'd0, pmem_read}, 32'd1);
    check_eq("drop_idle_b_addr", {16'd0, pmem_address}, 32'h0500);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'h7A5C;
    settle();
    check_eq("b_read_resp", {31'd0, mem_resp_b}, 32'd1);
    check_eq("b_read_rdata", {16'd0, mem_rdata_b}, 32'h7A5C);
    step();
    pmem_resp  = 1'b0;
    mem_read_b = 1'b0;
    step();

    // Last grant is B. A read plus B read+write together.
    mem_read_a    = 1'b1;
    mem_address_a = 16'h0A0A;
    mem_read_b    = 1'b1;
    mem_write_b   = 1'b1;
    mem_address_b = 16'h0B0B;
    mem_wmask_b   = 2'b10;
    mem_wdata_b   = 16'h1234;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("rr_first_a_read", {31'd0, pmem_read}, 32'd1);
    check_eq("rr_first_a_addr", {16'd0, pmem_address}, 32'h0A0A);
    pmem_resp = 1'b1;
    settle();
    check_eq("rr_first_a_resp", {31'd0, mem_resp_a}, 32'd1);
    step();
    pmem_resp  = 1'b0;
    mem_read_a = 1'b0;
    step();
`endif
    check_eq("rw_write_only", {31'd0, pmem_write}, 32'd1);
    check_eq("rw_no_read", {31'd0, pmem_read}, 32'd0);
    check_eq("rw_addr", {16'd0, pmem_address}, 32'h0B0B);
    check_eq("rw_wmask", {30'd0, pmem_wmask}, 32'd2);
    pmem_resp = 1'b1;
    settle();
    check_eq("rw_resp_b", {31'd0, mem_resp_b}, 32'd1);
    step();
    pmem_resp   = 1'b0;
    mem_read_b  = 1'b0;
    mem_write_b = 1'b0;
    step();
`ifndef ARB_ROUND_ROBIN_EN
    check_eq("fx_second_a_read", {31'd0, pmem_read}, 32'd1);
    check_eq("fx_second_a_addr", {16'd0, pmem_address}, 32'h0A0A);
    pmem_resp = 1'b1;
    settle();
    check_eq("fx_second_a_resp", {31'd0, mem_resp_a}, 32'd1);
    step();
    pmem_resp  = 1'b0;
    mem_read_a = 1'b0;
    step();
`endif

    // Reset in the middle of a B write
    mem_write_b   = 1'b1;
    mem_address_b = 16'h0700;
    mem_wmask_b   = 2'b11;
    step();
    check_eq("rstmid_write_on", {31'd0, pmem_write}, 32'd1);
    reset = 1'b1;
    settle();
    check_eq("rstmid_write_async", {31'd0, pmem_write}, 32'd0);
    check_eq("rstmid_addr_clr", {16'd0, pmem_address}, 32'd0);
    step();
    reset     = 1'b0;
    pmem_resp = 1'b1;
    settle();
    check_eq("rstmid_no_resp_b", {31'd0, mem_resp_b}, 32'd0);
    check_eq("rstmid_idle_write", {31'd0, pmem_write}, 32'd0);
    pmem_resp   = 1'b0;
    mem_write_b = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
